// File: rtl/dsi_pkg.sv
// Shared constants and types for the DSI video frame scheduler.
package dsi_pkg;

  // DSI data types emitted by the scheduler
  localparam logic [5:0] DT_VSS    = 6'h01;
  localparam logic [5:0] DT_HSS    = 6'h21;
  localparam logic [5:0] DT_BLANK  = 6'h19;
  localparam logic [5:0] DT_RGB888 = 6'h3E;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_FRAME_START = 3'd1,
    ST_SYNC_HDR    = 3'd2,
    ST_PIX_HDR     = 3'd3,
    ST_PAYLOAD     = 3'd4,
    ST_BLANK_HDR   = 3'd5,
    ST_CMD_SLOT    = 3'd6,
    ST_RESYNC      = 3'd7
  } state_t;

  // Debug view: FSM state plus the vertical region of the current line
  typedef struct packed {
    state_t state;
    logic   in_vsync;
    logic   in_vbp;
    logic   in_active;
    logic   in_vfp;
  } dbg_t;

endpackage

// File: rtl/dsi_frame_timing_cnt.sv
// Line counter for one frame plus vertical region decode.
// Vertical config is captured on i_load so the frame keeps its own timing.
module dsi_frame_timing_cnt #(
  parameter int VW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_advance,
  input  logic [VW-1:0] i_v_sync,
  input  logic [VW-1:0] i_v_bp,
  input  logic [VW-1:0] i_v_active,
  input  logic [VW-1:0] i_v_fp,
  output logic          o_in_vsync,
  output logic          o_in_vbp,
  output logic          o_in_active,
  output logic          o_in_vfp,
  output logic          o_first_line,
  output logic          o_first_active,
  output logic          o_last_active,
  output logic          o_last_line
);

  // Two extra bits so the sum of four VW-bit fields cannot wrap
  localparam int LW = VW + 2;

  logic [VW-1:0] r_vs;
  logic [VW-1:0] r_vbp;
  logic [VW-1:0] r_va;
  logic [VW-1:0] r_vfp;
  logic [LW-1:0] r_line;
  logic [LW-1:0] w_act_start;
  logic [LW-1:0] w_vfp_start;
  logic [LW-1:0] w_total;

  assign w_act_start = LW'(r_vs) + LW'(r_vbp);
  assign w_vfp_start = w_act_start + LW'(r_va);
  assign w_total     = w_vfp_start + LW'(r_vfp);

  // Shadow the vertical config and step the line counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs   <= '0;
      r_vbp  <= '0;
      r_va   <= '0;
      r_vfp  <= '0;
      r_line <= '0;
    end else if (i_load) begin
      r_vs   <= i_v_sync;
      r_vbp  <= i_v_bp;
      r_va   <= i_v_active;
      r_vfp  <= i_v_fp;
      r_line <= '0;
    end else if (i_advance && !o_last_line) begin
      r_line <= r_line + LW'(1);
    end
  end

  assign o_in_vsync     = (r_line < LW'(r_vs));
  assign o_in_vbp       = !o_in_vsync && (r_line < w_act_start);
  assign o_in_active    = (r_line >= w_act_start) && (r_line < w_vfp_start);
  assign o_in_vfp       = (r_line >= w_vfp_start);
  assign o_first_line   = (r_line == '0);
  assign o_first_active = (r_line == w_act_start);
  assign o_last_active  = (r_line == w_vfp_start - LW'(1));
  assign o_last_line    = (r_line == w_total - LW'(1));

endmodule

// File: rtl/dsi_video_frame_scheduler.sv
// Sequences one DSI video frame: per-line sync/pixel/blanking headers,
// pass-through pixel payload, one command slot per VFP line, and input
// framing checks with resynchronisation to the next end-of-frame word.
//
// Handshakes: a header or payload word moves when valid & ready are both
// high at a clock edge; valid and its data stay stable until accepted.
// in_ready mirrors pld_ready in PAYLOAD (zero-latency pass-through), is 1
// in RESYNC (drain), and 0 elsewhere.
module dsi_video_frame_scheduler
  import dsi_pkg::*;
#(
  parameter int HW = 16,
  parameter int VW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [HW-1:0] cfg_h_active,
  input  logic [15:0]   cfg_h_blank_wc,
  input  logic [VW-1:0] cfg_v_sync,
  input  logic [VW-1:0] cfg_v_bp,
  input  logic [VW-1:0] cfg_v_active,
  input  logic [VW-1:0] cfg_v_fp,
  input  logic [31:0]   in_data,
  input  logic          in_valid,
  input  logic          in_sop,
  input  logic          in_eop,
  output logic          in_ready,
  output logic          hdr_valid,
  output logic [5:0]    hdr_type,
  output logic [15:0]   hdr_wc,
  input  logic          hdr_ready,
  output logic [31:0]   pld_data,
  output logic          pld_valid,
  output logic          pld_last,
  input  logic          pld_ready,
  input  logic          cmd_req,
  output logic          cmd_grant,
  input  logic          cmd_done,
  output logic          sync_err,
  output dbg_t          dbg
);

  state_t        r_state;
  state_t        w_state_nxt;
  state_t        w_frame_end_state;
  logic [15:0]   r_h_pix_wc;
  logic [15:0]   r_h_blank_wc;
  logic [HW-1:0] r_h_last_idx;
  logic [HW-1:0] r_word_cnt;
  logic          r_flush;
  logic          r_sync_err;

  logic [HW+1:0] w_h_x3;
  logic          w_at_last;
  logic          w_load;
  logic          w_advance;
  logic          w_word_inc;
  logic          w_word_clr;
  logic          w_err;
  logic          w_flush_set;
  logic          w_is_first;
  logic          w_is_final;

  logic w_in_vsync;
  logic w_in_vbp;
  logic w_in_active;
  logic w_in_vfp;
  logic w_first_line;
  logic w_first_active;
  logic w_last_active;
  logic w_last_line;

  dsi_frame_timing_cnt #(.VW(VW)) u_timing (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_load         (w_load),
    .i_advance      (w_advance),
    .i_v_sync       (cfg_v_sync),
    .i_v_bp         (cfg_v_bp),
    .i_v_active     (cfg_v_active),
    .i_v_fp         (cfg_v_fp),
    .o_in_vsync     (w_in_vsync),
    .o_in_vbp       (w_in_vbp),
    .o_in_active    (w_in_active),
    .o_in_vfp       (w_in_vfp),
    .o_first_line   (w_first_line),
    .o_first_active (w_first_active),
    .o_last_active  (w_last_active),
    .o_last_line    (w_last_line)
  );

  // h_active * 3 bytes per line; h_active is a multiple of 4 so /4 is exact
  assign w_h_x3    = {2'b00, cfg_h_active} + {1'b0, cfg_h_active, 1'b0};
  assign w_at_last = (r_word_cnt == r_h_last_idx);
  assign sync_err  = r_sync_err;
  assign dbg       = {r_state, w_in_vsync, w_in_vbp, w_in_active, w_in_vfp};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Horizontal shadow config, word counter, flush flag and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_pix_wc   <= '0;
      r_h_blank_wc <= '0;
      r_h_last_idx <= '0;
      r_word_cnt   <= '0;
      r_flush      <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      if (w_load) begin
        r_h_pix_wc   <= 16'(w_h_x3);
        r_h_blank_wc <= cfg_h_blank_wc;
        r_h_last_idx <= w_h_x3[HW+1:2] - HW'(1);
      end
      if (w_load || w_word_clr)  r_word_cnt <= '0;
      else if (w_word_inc)       r_word_cnt <= r_word_cnt + HW'(1);
      if (w_load)                r_flush <= 1'b0;
      else if (w_flush_set)      r_flush <= 1'b1;
      if (w_err)                 r_sync_err <= 1'b1;
      else if (!enable)          r_sync_err <= 1'b0;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt       = r_state;
    w_frame_end_state = enable ? ST_FRAME_START : ST_IDLE;
    hdr_valid         = 1'b0;
    hdr_type          = 6'h00;
    hdr_wc            = 16'h0000;
    pld_data          = 32'h0;
    pld_valid         = 1'b0;
    pld_last          = 1'b0;
    in_ready          = 1'b0;
    cmd_grant         = 1'b0;
    w_load            = 1'b0;
    w_advance         = 1'b0;
    w_word_inc        = 1'b0;
    w_word_clr        = 1'b0;
    w_err             = 1'b0;
    w_flush_set       = 1'b0;
    w_is_first        = w_first_active && (r_word_cnt == '0);
    w_is_final        = w_last_active && w_at_last;

    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_FRAME_START;
      end

      ST_FRAME_START: begin
        w_load      = 1'b1;
        w_state_nxt = ST_SYNC_HDR;
      end

      ST_SYNC_HDR: begin
        hdr_valid = 1'b1;
        hdr_type  = (w_in_vsync && w_first_line) ? DT_VSS : DT_HSS;
        if (hdr_ready) w_state_nxt = w_in_active ? ST_PIX_HDR : ST_BLANK_HDR;
      end

      ST_PIX_HDR: begin
        hdr_valid = 1'b1;
        hdr_type  = DT_RGB888;
        hdr_wc    = r_h_pix_wc;
        if (hdr_ready) w_state_nxt = ST_PAYLOAD;
      end

      ST_PAYLOAD: begin
        if (r_flush) begin
          // Input already drained this frame: pad the line with zeros
          pld_valid = 1'b1;
          pld_last  = w_at_last;
          if (pld_ready) begin
            if (w_at_last) begin
              w_word_clr  = 1'b1;
              w_state_nxt = ST_BLANK_HDR;
            end else begin
              w_word_inc = 1'b1;
            end
          end
        end else begin
          pld_valid = in_valid;
          pld_data  = in_data;
          pld_last  = in_valid && w_at_last;
          in_ready  = pld_ready;
          if (in_valid && pld_ready) begin
            if ((w_is_first != in_sop) || (w_is_final != in_eop)) begin
              w_err      = 1'b1;
              w_word_clr = 1'b1;
              // An eop on the bad word means the stream is already drained
              if (in_eop) begin
                w_flush_set = 1'b1;
                w_state_nxt = ST_BLANK_HDR;
              end else begin
                w_state_nxt = ST_RESYNC;
              end
            end else if (w_at_last) begin
              w_word_clr  = 1'b1;
              w_state_nxt = ST_BLANK_HDR;
            end else begin
              w_word_inc = 1'b1;
            end
          end
        end
      end

      ST_RESYNC: begin
        in_ready = 1'b1;
        if (in_valid && in_eop) begin
          w_flush_set = 1'b1;
          w_state_nxt = ST_BLANK_HDR;
        end
      end

      ST_BLANK_HDR: begin
        hdr_valid = 1'b1;
        hdr_type  = DT_BLANK;
        hdr_wc    = r_h_blank_wc;
        if (hdr_ready) begin
          if (w_in_vfp && cmd_req) begin
            w_state_nxt = ST_CMD_SLOT;
          end else if (w_last_line) begin
            w_state_nxt = w_frame_end_state;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = ST_SYNC_HDR;
          end
        end
      end

      ST_CMD_SLOT: begin
        cmd_grant = 1'b1;
        if (cmd_done) begin
          if (w_last_line) begin
            w_state_nxt = w_frame_end_state;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = ST_SYNC_HDR;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dsi_video_frame_scheduler.sv
// Directed bench for dsi_video_frame_scheduler: header/payload streams are
// logged and compared against hand-built expected queues.
module tb_dsi_video_frame_scheduler;
  import dsi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        enable;
  logic [15:0] cfg_h_active;
  logic [15:0] cfg_h_blank_wc;
  logic [11:0] cfg_v_sync, cfg_v_bp, cfg_v_active, cfg_v_fp;
  logic [31:0] in_data;
  logic        in_valid, in_sop, in_eop, in_ready;
  logic        hdr_valid, hdr_ready;
  logic [5:0]  hdr_type;
  logic [15:0] hdr_wc;
  logic [31:0] pld_data;
  logic        pld_valid, pld_last, pld_ready;
  logic        cmd_req, cmd_grant, cmd_done;
  logic        sync_err;
  dbg_t        dbg;

  dsi_video_frame_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_h_active(cfg_h_active), .cfg_h_blank_wc(cfg_h_blank_wc),
    .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready),
    .hdr_valid(hdr_valid), .hdr_type(hdr_type), .hdr_wc(hdr_wc), .hdr_ready(hdr_ready),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_last(pld_last), .pld_ready(pld_ready),
    .cmd_req(cmd_req), .cmd_grant(cmd_grant), .cmd_done(cmd_done),
    .sync_err(sync_err), .dbg(dbg)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [21:0] hdr_log[$];     // {type, wc}; 6'h3F marks a command grant, wc = length
  logic [32:0] pld_log[$];     // {last, data}
  logic [21:0] exp_hdr_q[$];
  logic [32:0] exp_q[$];
  logic [33:0] src_q[$];       // {sop, eop, data}
  int stall_left = 0;
  int stall_seen = 0;
  int grant_len  = 0;
  bit throttle   = 0;
  bit took       = 0;

  typedef struct {
    logic [5:0]  typ;
    logic [15:0] wc;
  } hvec_t;
  hvec_t frame_tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Input word feeder: presents src_q[0], pops it once accepted
  initial begin
    in_valid = 0; in_data = 0; in_sop = 0; in_eop = 0;
    forever begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        in_valid = 1'b1;
        {in_sop, in_eop, in_data} = src_q[0];
      end else begin
        in_valid = 1'b0; in_sop = 0; in_eop = 0; in_data = 0;
      end
    end
  end

  // Header ready: optionally stalls the next RGB888 header for stall_left cycles
  initial begin
    hdr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && hdr_valid && hdr_type == 6'h3E) begin
        hdr_ready = 1'b0;
        stall_left--;
      end else begin
        hdr_ready = 1'b1;
      end
    end
  end

  // Payload ready: always high unless throttled randomly
  initial begin
    pld_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      pld_ready = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Command responder: raises cmd_done on the fifth grant cycle
  initial begin
    int gl;
    gl = 0;
    cmd_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cmd_grant) begin
        gl++;
        cmd_done = (gl == 5);
      end else begin
        gl = 0;
        cmd_done = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!cmd_grant && grant_len > 0) begin
      hdr_log.push_back({6'h3F, 16'(grant_len)});
      grant_len = 0;
    end
    if (cmd_grant) grant_len++;
    if (hdr_valid && hdr_ready) hdr_log.push_back({hdr_type, hdr_wc});
    if (pld_valid && pld_ready) pld_log.push_back({pld_last, pld_data});
    if (hdr_valid && !hdr_ready) begin
      stall_seen++;
      check("stall_type", hdr_type, 6'h3E);
      check("stall_wc", hdr_wc, 16'd24);
      check("stall_in_ready", in_ready, 1'b0);
    end
  end

  // ---------------- helpers ----------------
  task automatic push_hdrs(input logic [15:0] pix_wc);
    for (int i = 0; i < 12; i++)
      exp_hdr_q.push_back({frame_tbl[i].typ, (frame_tbl[i].typ == 6'h3E) ? pix_wc : frame_tbl[i].wc});
  endtask

  // Two active lines of wpl words each, sop on first and eop on last
  task automatic push_frame(input int wpl, input logic [31:0] base);
    for (int i = 0; i < 2 * wpl; i++) begin
      logic [31:0] d;
      d = base + 32'(i);
      src_q.push_back({i == 0, i == 2 * wpl - 1, d});
      exp_q.push_back({(i % wpl) == wpl - 1, d});
    end
  endtask

  task automatic wait_hdrs(input int n, input string tag);
    int t;
    t = 0;
    while (hdr_log.size() < n && t < 4000) begin @(posedge clk); #1; t++; end
    check({tag, "_wait_hdrs"}, hdr_log.size() >= n, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (dbg.state != ST_IDLE && t < 4000) begin @(posedge clk); #1; t++; end
    check({tag, "_idle"}, dbg.state, ST_IDLE);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_hdr_count"}, hdr_log.size(), exp_hdr_q.size());
    for (int i = 0; i < exp_hdr_q.size(); i++)
      if (i < hdr_log.size()) check($sformatf("%s_hdr%0d", tag, i), hdr_log[i], exp_hdr_q[i]);
    check({tag, "_pld_count"}, pld_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < pld_log.size()) check($sformatf("%s_pld%0d", tag, i), pld_log[i], exp_q[i]);
    hdr_log.delete(); pld_log.delete(); exp_hdr_q.delete(); exp_q.delete();
  endtask

  task automatic run_frame(input int drop_at, input string tag);
    enable = 1'b1;
    wait_hdrs(drop_at, tag);
    enable = 1'b0;
    wait_idle(tag);
    compare_logs(tag);
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {hdr_valid, hdr_type, hdr_wc, pld_data, pld_valid, pld_last,
                in_ready, cmd_grant, sync_err}, 64'h0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Expected header order for v = 1/1/2/1 (RGB888 wc filled per frame)
    frame_tbl[0]  = '{6'h01, 16'h0000};
    frame_tbl[1]  = '{6'h19, 16'h0040};
    frame_tbl[2]  = '{6'h21, 16'h0000};
    frame_tbl[3]  = '{6'h19, 16'h0040};
    frame_tbl[4]  = '{6'h21, 16'h0000};
    frame_tbl[5]  = '{6'h3E, 16'h0000};
    frame_tbl[6]  = '{6'h19, 16'h0040};
    frame_tbl[7]  = '{6'h21, 16'h0000};
    frame_tbl[8]  = '{6'h3E, 16'h0000};
    frame_tbl[9]  = '{6'h19, 16'h0040};
    frame_tbl[10] = '{6'h21, 16'h0000};
    frame_tbl[11] = '{6'h19, 16'h0040};

    rst_n = 1'b0; enable = 0; cmd_req = 0;
    cfg_h_active = 16'd8; cfg_h_blank_wc = 16'h0040;
    cfg_v_sync = 12'd1; cfg_v_bp = 12'd1; cfg_v_active = 12'd2; cfg_v_fp = 12'd1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_outputs");
    check("reset_state", dbg.state, ST_IDLE);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic frame, all ready high
    push_hdrs(16'd24);
    push_frame(6, 32'hA000_0000);
    run_frame(3, "basic");
    check("basic_sync_err", sync_err, 1'b0);

    // RGB888 header stalled 3 cycles, payload backpressure
    stall_seen = 0; stall_left = 3; throttle = 1;
    push_hdrs(16'd24);
    push_frame(6, 32'hB000_0000);
    run_frame(3, "stall");
    throttle = 0;
    check("stall_cycles", stall_seen, 3);

    // Command slots: cmd_req high all frame, two VFP lines
    cfg_v_fp = 12'd2; cmd_req = 1'b1;
    push_hdrs(16'd24);
    exp_hdr_q.push_back({6'h3F, 16'd5});
    exp_hdr_q.push_back({6'h21, 16'h0000});
    exp_hdr_q.push_back({6'h19, 16'h0040});
    exp_hdr_q.push_back({6'h3F, 16'd5});
    push_frame(6, 32'hC000_0000);
    run_frame(3, "cmd");
    cmd_req = 1'b0; cfg_v_fp = 12'd1;

    // First active word lacks sop: drain to eop, pad remaining line with zeros
    push_hdrs(16'd24);
    for (int i = 0; i < 12; i++) src_q.push_back({1'b0, i == 11, 32'hD000_0000 + 32'(i)});
    exp_q.push_back({1'b0, 32'hD000_0000});
    for (int i = 0; i < 6; i++) exp_q.push_back({i == 5, 32'h0});
    enable = 1'b1;
    wait_hdrs(11, "sync");
    check("sync_err_set", sync_err, 1'b1);
    check("sync_drained", src_q.size(), 0);
    enable = 1'b0;
    wait_idle("sync");
    compare_logs("sync");
    check("sync_err_cleared", sync_err, 1'b0);

    // Config change mid-frame; back-to-back frame picks up new h_active
    push_hdrs(16'd24);
    push_hdrs(16'd36);
    push_frame(6, 32'hE000_0000);
    push_frame(9, 32'hE100_0000);
    enable = 1'b1;
    wait_hdrs(1, "cfgchg");
    cfg_h_active = 16'd12;
    wait_hdrs(13, "cfgchg");
    enable = 1'b0;
    wait_idle("cfgchg");
    compare_logs("cfgchg");
    cfg_h_active = 16'd8;

    // Asynchronous reset while in PAYLOAD, then a clean restart
    push_frame(6, 32'hF000_0000);
    enable = 1'b1;
    begin
      int t;
      t = 0;
      while (!(dbg.state == ST_PAYLOAD && pld_log.size() >= 2) && t < 4000) begin
        @(posedge clk); #1; t++;
      end
      check("rst_reach_payload", dbg.state, ST_PAYLOAD);
    end
    #1;
    rst_n = 1'b0; enable = 1'b0;
    src_q.delete();
    #1;
    check_outputs_zero("rst_async_outputs");
    check("rst_async_state", dbg.state, ST_IDLE);
    repeat (2) @(posedge clk);
    #1;
    hdr_log.delete(); pld_log.delete(); exp_hdr_q.delete(); exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_hdrs(16'd24);
    push_frame(6, 32'h1234_0000);
    run_frame(3, "restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
